// File: rtl/xram_arb_pkg.sv
// rtl/xram_arb_pkg.sv - shared types and widths for the XRAM arbiter
package xram_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int ID_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin priority encoder, first set bit at or above ptr with wrap
module rr_pick
  import xram_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] idx,
  output logic            found
);

  logic [NREQ-1:0] rot;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign rot = NREQ'({req, req} >> ptr);

  always_comb begin
    int s;
    s     = 0;
    idx   = '0;
    found = 1'b0;
    // Descending scan so the lowest rotated position wins.
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        s = int'(ptr) + j;
        if (s >= NREQ) s = s - NREQ;
        idx   = ID_W'(s);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xram_arbiter.sv
// rtl/xram_arbiter.sv - round-robin XRAM arbiter with burst cap and ack watchdog
module xram_arbiter
  import xram_arb_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_stb,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  input  logic [DATA_W*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ack,
  output logic [DATA_W-1:0]        req_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_stb,
  output logic                     mem_wr,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id,
  output logic                     timeout_err,
  output logic [ID_W-1:0]          err_id
);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("xram_arbiter: NREQ must be within 2..8");
  end

  localparam logic [7:0]  BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [15:0] WD_LAST    = 16'(TIMEOUT - 1);

  arb_state_t      state, state_n;
  logic [ID_W-1:0] rr_ptr, rr_n;
  logic [ID_W-1:0] grant_n;
  logic [7:0]      burst_cnt, burst_n;
  logic [15:0]     wd_cnt, wd_n;
  logic            terr_n;
  logic [ID_W-1:0] err_id_n;
  logic [ID_W-1:0] pick_idx;
  logic            pick_found;
  logic            ack_g;
  logic            drop;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req   (req_stb),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign busy      = (state == GRANT);
  assign req_rdata = mem_rdata;
  assign ack_g     = mem_ack & mem_stb;

  always_comb begin
    mem_stb   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    req_ack   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (busy && grant_id == ID_W'(i)) begin
        mem_stb    = req_stb[i];
        mem_wr     = req_wr[i] & req_stb[i];
        mem_addr   = req_addr[ADDR_W*i +: ADDR_W];
        mem_wdata  = req_wdata[DATA_W*i +: DATA_W];
        req_ack[i] = mem_ack & req_stb[i];
      end
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant_id;
    rr_n     = rr_ptr;
    burst_n  = burst_cnt;
    wd_n     = wd_cnt;
    terr_n   = 1'b0;
    err_id_n = err_id;
    drop     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          grant_n = pick_idx;
          burst_n = '0;
          wd_n    = '0;
        end
      end
      GRANT: begin
        if (!mem_stb) begin
          drop = 1'b1;
        end else if (ack_g) begin
          // An ack on the watchdog threshold cycle still counts as progress.
          if (burst_cnt == BURST_LAST) begin
            drop = 1'b1;
          end else begin
            burst_n = burst_cnt + 8'd1;
            wd_n    = '0;
          end
        end else if (wd_cnt == WD_LAST) begin
          drop     = 1'b1;
          terr_n   = 1'b1;
          err_id_n = grant_id;
        end else begin
          wd_n = wd_cnt + 16'd1;
        end
        if (drop) begin
          state_n = IDLE;
          rr_n    = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
          burst_n = '0;
          wd_n    = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_id    <= '0;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
      err_id      <= '0;
    end else begin
      state       <= state_n;
      grant_id    <= grant_n;
      rr_ptr      <= rr_n;
      burst_cnt   <= burst_n;
      wd_cnt      <= wd_n;
      timeout_err <= terr_n;
      err_id      <= err_id_n;
    end
  end

endmodule
